// File: rtl/blf_seq_pkg.sv
// Shared types and constants for the backscatter-link divider sequencer.
// Contents: FSM state enum, reset TRcal, counter widths and the T1
// load-value helper.
package blf_seq_pkg;

  localparam int unsigned TRCAL_W   = 10;
  localparam int unsigned TPRI_W    = 9;
  localparam int unsigned T1_CNT_W  = 10;
  localparam int unsigned T2_CNT_W  = 5;
  localparam int unsigned UPD_CNT_W = 3;

  // M=8 at DR=0, matching the divider's own reset
  localparam logic [TRCAL_W-1:0] TRCAL_RST = 10'd128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UPD  = 3'd1,
    T1   = 3'd2,
    TX   = 3'd3,
    T2   = 3'd4
  } state_e;

  // T1 counter load value: max(tpri_10,1) + extra - 1
  function automatic logic [T1_CNT_W-1:0] t1_load_val(
    input logic [TPRI_W-1:0]   tpri,
    input logic [T1_CNT_W-1:0] extra
  );
    logic [T1_CNT_W-1:0] base;
    base = (tpri == '0) ? T1_CNT_W'(1) : T1_CNT_W'(tpri);
    return base + extra - T1_CNT_W'(1);
  endfunction

endpackage

// File: rtl/blf_tick_cnt.sv
// Loadable down-counter with registered zero / one flags.
// Ports:
//   clk_i, rst_i   : clock, async active-high reset
//   clr_i          : force count to 0 (highest priority)
//   load_i         : load load_val_i
//   dec_i          : decrement, saturating at 0
//   zero_o, one_o  : count == 0 / count == 1
module blf_tick_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, one_q;

  // Next count: clear > load > decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Flags decoded from the next count so they line up with cnt_q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
      one_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
      one_q  <= (cnt_d == W'(1));
    end
  end

  assign zero_o = zero_q;
  assign one_o  = one_q;

endmodule

// File: rtl/blf_seq_ctrl.sv
// Backscatter-link divider sequencer: latches TRcal/DR from Query, strobes
// the divider's M/N load, and runs the per-reply T1 / TX / T2 sequence.
// Ports:
//   clk_1_92m, rst           : clock, async active-high reset
//   query_vld/trcal_in/dr_in : Query parameters from the decoder
//   reply_req, reply_done    : reply pending / last symbol sent
//   abort                    : kill any sequence
//   tpri_10                  : 10*Tpri in clk_1_92m cycles
//   clk_60k                  : divider 60 kHz output, sampled as data
//   TRcal, DR, blc_update, div_en, K60_EN : divider controls
//   enc_start, t2_timeout    : one-cycle pulses
//   busy                     : not IDLE
module blf_seq_ctrl
  import blf_seq_pkg::*;
#(
  parameter int unsigned UPD_HOLD = 2,
  parameter int unsigned T1_EXTRA = 0,
  parameter int unsigned T2_TICKS = 4
) (
  input  logic               clk_1_92m,
  input  logic               rst,
  input  logic               query_vld,
  input  logic [TRCAL_W-1:0] trcal_in,
  input  logic               dr_in,
  input  logic               reply_req,
  input  logic               reply_done,
  input  logic               abort,
  input  logic [TPRI_W-1:0]  tpri_10,
  input  logic               clk_60k,
  output logic [TRCAL_W-1:0] TRcal,
  output logic               DR,
  output logic               blc_update,
  output logic               div_en,
  output logic               K60_EN,
  output logic               enc_start,
  output logic               t2_timeout,
  output logic               busy
);

  state_e                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [TRCAL_W-1:0]     trcal_q, trcal_d;
  logic                   dr_q, dr_d;
  logic                   blc_update_q, blc_update_d;
  logic                   div_en_q, div_en_d;
  logic                   k60_en_q, k60_en_d;
  logic                   enc_start_q, enc_start_d;
  logic                   t2_timeout_q, t2_timeout_d;
  logic                   busy_q, busy_d;
  logic [UPD_CNT_W-1:0]   upd_cnt_q, upd_cnt_d;
  logic                   clk60_q;

  logic                   edge60_c;
  logic                   go_t1_c, go_upd_c;
  logic                   cnt_clr_c;
  logic                   t1_load_c, t1_dec_c, t1_zero, t1_one;
  logic                   t2_load_c, t2_dec_c, t2_zero, t2_one;
  logic [T1_CNT_W-1:0]    t1_val_c;

  assign edge60_c = clk_60k & ~clk60_q;
  assign t1_val_c = t1_load_val(tpri_10, T1_CNT_W'(T1_EXTRA));

  // T1 wait counter
  blf_tick_cnt #(.W(T1_CNT_W)) u_t1_cnt (
    .clk_i      (clk_1_92m),
    .rst_i      (rst),
    .clr_i      (cnt_clr_c),
    .load_i     (t1_load_c),
    .load_val_i (t1_val_c),
    .dec_i      (t1_dec_c),
    .zero_o     (t1_zero),
    .one_o      (t1_one)
  );

  // T2 clk_60k edge counter
  blf_tick_cnt #(.W(T2_CNT_W)) u_t2_cnt (
    .clk_i      (clk_1_92m),
    .rst_i      (rst),
    .clr_i      (cnt_clr_c),
    .load_i     (t2_load_c),
    .load_val_i (T2_CNT_W'(T2_TICKS)),
    .dec_i      (t2_dec_c),
    .zero_o     (t2_zero),
    .one_o      (t2_one)
  );

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    trcal_d      = trcal_q;
    dr_d         = dr_q;
    blc_update_d = 1'b0;
    div_en_d     = div_en_q;
    k60_en_d     = k60_en_q;
    enc_start_d  = 1'b0;
    t2_timeout_d = 1'b0;
    upd_cnt_d    = upd_cnt_q;
    go_t1_c      = 1'b0;
    go_upd_c     = 1'b0;
    cnt_clr_c    = 1'b0;
    t1_load_c    = 1'b0;
    t1_dec_c     = 1'b0;
    t2_load_c    = 1'b0;
    t2_dec_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (query_vld) begin
          go_upd_c = 1'b1;
          if (reply_req) pending_d = 1'b1;
        end else if (reply_req) begin
          go_t1_c = 1'b1;
        end
      end
      UPD: begin
        if (reply_req) pending_d = 1'b1;
        if (upd_cnt_q == '0) begin
          if (pending_q || reply_req) go_t1_c = 1'b1;
          else                        state_d = IDLE;
        end else begin
          upd_cnt_d    = upd_cnt_q - UPD_CNT_W'(1);
          blc_update_d = 1'b1;
        end
      end
      T1: begin
        t1_dec_c = 1'b1;
        // enc_start is issued one cycle early so it lands in the zero cycle
        if (t1_zero)     state_d     = TX;
        else if (t1_one) enc_start_d = 1'b1;
      end
      TX: begin
        if (reply_done) begin
          state_d   = T2;
          div_en_d  = 1'b0;
          k60_en_d  = 1'b1;
          t2_load_c = 1'b1;
        end
      end
      T2: begin
        t2_dec_c = edge60_c;
        if (query_vld) begin
          go_upd_c = 1'b1;
          k60_en_d = 1'b0;
          if (reply_req) pending_d = 1'b1;
        end else if (reply_req) begin
          go_t1_c  = 1'b1;
          k60_en_d = 1'b0;
        end else if (edge60_c && (t2_one || t2_zero)) begin
          // zero is unreachable here; treated as already expired
          t2_timeout_d = 1'b1;
          k60_en_d     = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_upd_c) begin
      state_d      = UPD;
      trcal_d      = trcal_in;
      dr_d         = dr_in;
      blc_update_d = 1'b1;
      upd_cnt_d    = UPD_CNT_W'(UPD_HOLD - 1);
    end

    if (go_t1_c) begin
      state_d     = T1;
      pending_d   = 1'b0;
      div_en_d    = 1'b1;
      t1_load_c   = 1'b1;
      enc_start_d = (t1_val_c == '0);
    end

    // abort overrides everything except the latched TRcal/DR
    if (abort) begin
      state_d      = IDLE;
      pending_d    = 1'b0;
      trcal_d      = trcal_q;
      dr_d         = dr_q;
      blc_update_d = 1'b0;
      div_en_d     = 1'b0;
      k60_en_d     = 1'b0;
      enc_start_d  = 1'b0;
      t2_timeout_d = 1'b0;
      upd_cnt_d    = '0;
      cnt_clr_c    = 1'b1;
      t1_load_c    = 1'b0;
      t2_load_c    = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_1_92m or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      trcal_q      <= TRCAL_RST;
      dr_q         <= 1'b0;
      blc_update_q <= 1'b0;
      div_en_q     <= 1'b0;
      k60_en_q     <= 1'b0;
      enc_start_q  <= 1'b0;
      t2_timeout_q <= 1'b0;
      busy_q       <= 1'b0;
      upd_cnt_q    <= '0;
      clk60_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      trcal_q      <= trcal_d;
      dr_q         <= dr_d;
      blc_update_q <= blc_update_d;
      div_en_q     <= div_en_d;
      k60_en_q     <= k60_en_d;
      enc_start_q  <= enc_start_d;
      t2_timeout_q <= t2_timeout_d;
      busy_q       <= busy_d;
      upd_cnt_q    <= upd_cnt_d;
      clk60_q      <= clk_60k;
    end
  end

  assign TRcal      = trcal_q;
  assign DR         = dr_q;
  assign blc_update = blc_update_q;
  assign div_en     = div_en_q;
  assign K60_EN     = k60_en_q;
  assign enc_start  = enc_start_q;
  assign t2_timeout = t2_timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_blf_seq_ctrl.sv
// Bench for blf_seq_ctrl: directed scenarios plus random pulses, every cycle
// compared against a deadline-based reference model.
module tb_blf_seq_ctrl;

  localparam int unsigned UPD_HOLD = 2;
  localparam int unsigned T1_EXTRA = 0;
  localparam int unsigned T2_TICKS = 4;

  localparam int MD_IDLE = 0;
  localparam int MD_UPD  = 1;
  localparam int MD_T1   = 2;
  localparam int MD_TX   = 3;
  localparam int MD_T2   = 4;

  logic       clk_1_92m = 1'b0;
  logic       rst;
  logic       query_vld, dr_in, reply_req, reply_done, abort, clk_60k;
  logic [9:0] trcal_in;
  logic [8:0] tpri_10;
  logic [9:0] TRcal;
  logic       DR, blc_update, div_en, K60_EN, enc_start, t2_timeout, busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model state: absolute-cycle deadlines rather than counters
  int         m_mode, m_upd_last, m_enc_at, m_edges;
  bit         m_pend, m_prev60;
  logic [9:0] exp_tr;
  bit         exp_dr, exp_blc, exp_div, exp_k60, exp_enc, exp_to, exp_busy;

  blf_seq_ctrl #(
    .UPD_HOLD (UPD_HOLD),
    .T1_EXTRA (T1_EXTRA),
    .T2_TICKS (T2_TICKS)
  ) dut (
    .clk_1_92m  (clk_1_92m),
    .rst        (rst),
    .query_vld  (query_vld),
    .trcal_in   (trcal_in),
    .dr_in      (dr_in),
    .reply_req  (reply_req),
    .reply_done (reply_done),
    .abort      (abort),
    .tpri_10    (tpri_10),
    .clk_60k    (clk_60k),
    .TRcal      (TRcal),
    .DR         (DR),
    .blc_update (blc_update),
    .div_en     (div_en),
    .K60_EN     (K60_EN),
    .enc_start  (enc_start),
    .t2_timeout (t2_timeout),
    .busy       (busy)
  );

  always #5 clk_1_92m = ~clk_1_92m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("TRcal",      32'(TRcal),      32'(exp_tr));
    chk("DR",         32'(DR),         32'(exp_dr));
    chk("blc_update", 32'(blc_update), 32'(exp_blc));
    chk("div_en",     32'(div_en),     32'(exp_div));
    chk("K60_EN",     32'(K60_EN),     32'(exp_k60));
    chk("enc_start",  32'(enc_start),  32'(exp_enc));
    chk("t2_timeout", 32'(t2_timeout), 32'(exp_to));
    chk("busy",       32'(busy),       32'(exp_busy));
  endtask

  task automatic model_reset();
    m_mode = MD_IDLE; m_pend = 0; m_prev60 = 0; m_edges = 0;
    m_upd_last = 0; m_enc_at = 0;
    exp_tr = 10'd128; exp_dr = 0; exp_blc = 0; exp_div = 0;
    exp_k60 = 0; exp_enc = 0; exp_to = 0; exp_busy = 0;
  endtask

  task automatic start_upd(input int n);
    exp_tr = trcal_in; exp_dr = dr_in;
    m_mode = MD_UPD; m_upd_last = n + int'(UPD_HOLD); exp_blc = 1;
    if (reply_req) m_pend = 1;
  endtask

  task automatic start_t1(input int n);
    int tp;
    tp = (tpri_10 == 9'd0) ? 1 : int'(tpri_10);
    m_mode = MD_T1; m_pend = 0; exp_div = 1;
    m_enc_at = n + tp + int'(T1_EXTRA);
    exp_enc = (m_enc_at == n + 1);
  endtask

  // Advance the model from cycle n (current inputs) to cycle n+1
  task automatic model_step();
    int n;
    bit edge60;
    n = cyc;
    edge60 = clk_60k && !m_prev60;
    exp_blc = 0; exp_enc = 0; exp_to = 0;
    if (abort) begin
      m_mode = MD_IDLE; m_pend = 0; exp_div = 0; exp_k60 = 0;
    end else begin
      case (m_mode)
        MD_IDLE: begin
          if (query_vld)      start_upd(n);
          else if (reply_req) start_t1(n);
        end
        MD_UPD: begin
          if (reply_req) m_pend = 1;
          if (n + 1 <= m_upd_last) exp_blc = 1;
          else if (m_pend)         start_t1(n);
          else                     m_mode = MD_IDLE;
        end
        MD_T1: begin
          if (n == m_enc_at)          m_mode = MD_TX;
          else if (n + 1 == m_enc_at) exp_enc = 1;
        end
        MD_TX: begin
          if (reply_done) begin
            m_mode = MD_T2; exp_div = 0; exp_k60 = 1; m_edges = 0;
          end
        end
        MD_T2: begin
          if (query_vld) begin
            exp_k60 = 0; start_upd(n);
          end else if (reply_req) begin
            exp_k60 = 0; start_t1(n);
          end else if (edge60) begin
            m_edges++;
            if (m_edges == int'(T2_TICKS)) begin
              exp_to = 1; exp_k60 = 0; m_mode = MD_IDLE;
            end
          end
        end
        default: m_mode = MD_IDLE;
      endcase
    end
    exp_busy = (m_mode != MD_IDLE);
    m_prev60 = clk_60k;
    cyc++;
  endtask

  // One clock: compare current outputs, step model, clear pulses
  task automatic tick();
    check_all();
    model_step();
    @(negedge clk_1_92m);
    query_vld = 0; reply_req = 0; reply_done = 0; abort = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  int lat, cnt, c60_cnt;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1; query_vld = 0; trcal_in = '0; dr_in = 0; reply_req = 0;
    reply_done = 0; abort = 0; tpri_10 = '0; clk_60k = 0;
    model_reset();
    repeat (3) @(negedge clk_1_92m);
    check_all();
    rst = 0;
    idle(2);

    // Query latch and M/N update strobe
    trcal_in = 10'd200; dr_in = 1; query_vld = 1;
    tick();
    chk("q_trcal", 32'(TRcal), 32'd200);
    chk("q_dr", 32'(DR), 32'd1);
    chk("q_blc1", 32'(blc_update), 32'd1);
    tick();
    chk("q_blc2", 32'(blc_update), 32'd1);
    tick();
    chk("q_blc_end", 32'(blc_update), 32'd0);
    chk("q_busy_end", 32'(busy), 32'd0);
    idle(2);

    // Full reply sequence, tpri_10=80
    tpri_10 = 9'd80; reply_req = 1;
    tick();
    chk("t1_div_en", 32'(div_en), 32'd1);
    lat = 1;
    while (enc_start !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk("enc_latency", 32'(lat), 32'd80);
    idle(5);
    reply_done = 1;
    tick();
    chk("t2_div_en", 32'(div_en), 32'd0);
    chk("t2_k60", 32'(K60_EN), 32'd1);
    for (int i = 0; i < 4; i++) begin
      clk_60k = 1; tick();
      if (i == 3) begin
        chk("t2_timeout", 32'(t2_timeout), 32'd1);
        chk("t2_k60_off", 32'(K60_EN), 32'd0);
      end
      tick(); clk_60k = 0; tick(); tick();
    end
    chk("t2_idle", 32'(busy), 32'd0);

    // Query and reply together: update first, reply not lost
    tpri_10 = 9'd5; trcal_in = 10'd300; dr_in = 0;
    query_vld = 1; reply_req = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (enc_start === 1'b1) cnt++; end
    chk("qr_enc_cnt", 32'(cnt), 32'd1);
    // Stray query while in TX is dropped
    trcal_in = 10'd77; query_vld = 1;
    tick();
    chk("tx_q_ign", 32'(TRcal), 32'd300);

    // reply_req on the 2nd T2 edge re-enters T1
    reply_done = 1; tick();
    clk_60k = 1; tick(); tick(); clk_60k = 0; tick(); tick();
    clk_60k = 1; reply_req = 1; tick();
    chk("t2rr_k60", 32'(K60_EN), 32'd0);
    chk("t2rr_div", 32'(div_en), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      clk_60k = (i % 4) < 2; tick();
      if (t2_timeout === 1'b1) cnt++;
    end
    chk("t2rr_no_to", 32'(cnt), 32'd0);

    // Abort mid-TX
    abort = 1; tick();
    chk("abtx_div", 32'(div_en), 32'd0);
    chk("abtx_busy", 32'(busy), 32'd0);
    chk("abtx_trcal", 32'(TRcal), 32'd300);

    // Abort mid-T1
    tpri_10 = 9'd80; reply_req = 1; idle(10);
    abort = 1; tick();
    chk("abt1_div", 32'(div_en), 32'd0);
    chk("abt1_k60", 32'(K60_EN), 32'd0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (enc_start === 1'b1) cnt++; end
    chk("abt1_no_enc", 32'(cnt), 32'd0);

    // tpri_10 = 0 behaves as 1
    tpri_10 = 9'd0; reply_req = 1; tick();
    chk("tp0_enc", 32'(enc_start), 32'd1);
    abort = 1; tick();
    // Stray reply_done in IDLE
    reply_done = 1; tick();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_div", 32'(div_en), 32'd0);

    // Random pulses against the model
    c60_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      trcal_in = 10'($urandom); dr_in = 1'($urandom);
      if ($urandom_range(99) < 2)  query_vld = 1;
      if ($urandom_range(99) < 4)  reply_req = 1;
      if ($urandom_range(99) < 6)  reply_done = 1;
      if ($urandom_range(999) < 5) abort = 1;
      if ($urandom_range(99) < 3)  tpri_10 = 9'($urandom_range(30));
      if ($urandom_range(999) < 3) tpri_10 = 9'($urandom);
      if (c60_cnt == 0) begin
        clk_60k = ~clk_60k; c60_cnt = $urandom_range(5, 1);
      end else begin
        c60_cnt--;
      end
      tick();
    end
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
